seq_det_ctrl: RTL and testbench

- Controller that configures, arms and runs a programmable Moore serial-sequence detector, then counts matches until a target is reached.
- Replaces fixed per-pattern detectors (e.g. 0001) with one run-time-configurable block.
- Sits between a config/host side (cfg_*, start, busy, done) and a serial bit source (x, x_valid).

---
 rtl/seq_det_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Run-time programmable Moore serial-sequence detector with a small run
// controller. The host loads a shadow configuration (pattern, length,
// overlap mode, match target) and pulses start. The block then samples the
// serial stream x on every x_valid cycle, raises z for one cycle after each
// match and counts matches until the target is reached (or forever when the
// target is 0). abort returns the block to IDLE from any state.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   cfg_we       load shadow config (only in IDLE or DONE)
//   cfg_pattern  pattern, bit [cfg_len-1] is the first bit received
//   cfg_len      pattern length, legal 1..PAT_W
//   cfg_overlap  1 = overlapping matches, 0 = matched bits are consumed
//   cfg_target   matches that end a run, 0 = run until abort
//   start        single-cycle run request (IDLE or DONE)
//   abort        go to IDLE next cycle, wins over start
//   x, x_valid   serial data bit and its qualifier
//   z            registered match flag, one cycle per match
//   match_cnt    matches in the current run (saturating)
//   busy         high in ARM or RUN
//   done         high in DONE
//   cfg_err      sticky flag for an illegal cfg_len write
//   dbg_state    current controller state (0 idle, 1 arm, 2 run, 3 done)
//
// Handshake: there is no backpressure. A bit is consumed on every rising edge
// where the block is in RUN and x_valid=1; x is ignored otherwise.
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             x,
   input  logic             x_valid,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_arm  = 2'd1,
      st_run  = 2'd2,
      st_done = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   state_t state, state_next;

   // shadow configuration
   logic [PAT_W-1:0] sh_pattern;
   logic [LEN_W-1:0] sh_len;
   logic             sh_overlap;
   logic [CNT_W-1:0] sh_target;

   // detector datapath
   logic [PAT_W-1:0] hist;
   logic [LEN_W-1:0] fill;

   logic [PAT_W:0]   window;
   logic [PAT_W:0]   len_mask;
   logic             fill_ok;
   logic             hit;
   logic [CNT_W-1:0] cnt_inc;
   logic             terminal;
   logic             cfg_open;
   logic             len_legal;

   // ---------------------------------------------------------------------------
   // Next state and match decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      // the incoming bit joins the history so a match is seen on the edge
      // that samples the last pattern bit
      window     = {hist, x};
      len_mask   = '0;
      for (int i = 0; i <= PAT_W; i++) begin
         len_mask[i] = (i < int'(sh_len));
      end
      fill_ok  = (({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, sh_len});
      hit      = (state == st_run) && x_valid && fill_ok &&
                 (((window ^ {1'b0, sh_pattern}) & len_mask) == '0);
      cnt_inc  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
      terminal = hit && (sh_target != '0) && (cnt_inc == sh_target);

      case (state)
         st_idle: if (start)    state_next = st_arm;
         st_arm:                state_next = st_run;
         st_run:  if (terminal) state_next = st_done;
         st_done: if (start)    state_next = st_arm;
         default:               state_next = st_idle;
      endcase

      if (abort) state_next = st_idle;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= st_idle;
      else      state <= state_next;
   end

   // ---------------------------------------------------------------------------
   // Shadow configuration
   // ---------------------------------------------------------------------------
   assign cfg_open  = (state == st_idle) || (state == st_done);
   assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_pattern <= '0;
         sh_len     <= LEN_W'(1);
         sh_overlap <= 1'b1;
         sh_target  <= '0;
         cfg_err    <= 1'b0;
      end else if (cfg_we && cfg_open) begin
         if (len_legal) begin
            sh_pattern <= cfg_pattern;
            sh_len     <= cfg_len;
            sh_overlap <= cfg_overlap;
            sh_target  <= cfg_target;
            cfg_err    <= 1'b0;
         end else begin
            cfg_err    <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Detector datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist      <= '0;
         fill      <= '0;
         match_cnt <= '0;
         z         <= 1'b0;
      end else if (abort) begin
         // count is held so the host can read the partial result
         z <= 1'b0;
      end else begin
         case (state)
            st_arm: begin
               hist      <= '0;
               fill      <= '0;
               match_cnt <= '0;
               z         <= 1'b0;
            end
            st_run: begin
               if (x_valid) begin
                  hist <= window[PAT_W-1:0];
                  z    <= hit;
                  if (hit) match_cnt <= cnt_inc;
                  // non-overlap mode forgets every bit that took part in the match
                  if (hit && !sh_overlap)  fill <= '0;
                  else if (fill != LEN_MAX) fill <= fill + LEN_W'(1);
               end else begin
                  z <= 1'b0;
               end
            end
            default: z <= 1'b0;
         endcase
      end
   end

   assign busy      = (state == st_arm) || (state == st_run);
   assign done      = (state == st_done);
   assign dbg_state = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//
// Directed bench for seq_det_ctrl. Inputs are driven 1 ns after the rising
// edge and outputs are checked at the same point, so every check sees the
// result of the edge that just happened.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             abort;
   logic             x;
   logic             x_valid;
   logic             z;
   logic [CNT_W-1:0] match_cnt;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic [1:0]       dbg_state;

   int total = 0;
   int bad   = 0;

   seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .x           (x),
      .x_valid     (x_valid),
      .z           (z),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // driver and checker tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                            input logic ov, input logic [7:0] tgt);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ov;
      cfg_target  = tgt;
      cfg_we      = 1'b1;
      tick();
      cfg_we      = 1'b0;
   endtask

   task automatic start_run(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_arm_state"}, dbg_state, 2'd1);
      chk({tag, "_arm_busy"}, busy, 1'b1);
      tick();
      chk({tag, "_run_state"}, dbg_state, 2'd2);
      chk({tag, "_run_cnt0"}, match_cnt, 8'd0);
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // one valid bit; z after the edge reflects whether this bit completed a match
   task automatic send_bit(input string tag, input logic b, input logic exp_z);
      x       = b;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      x       = 1'b0;
      chk(tag, z, exp_z);
   endtask

   // four valid bits, first bit is bits[3]
   task automatic send4(input string tag, input logic [3:0] bits, input logic [3:0] exp_z);
      for (int i = 3; i >= 0; i--) begin
         send_bit($sformatf("%s_b%0d", tag, 3 - i), bits[i], exp_z[i]);
      end
   endtask

   // ---------------------------------------------------------------------------
   // directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst         = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_target  = '0;
      start       = 1'b0;
      abort       = 1'b0;
      x           = 1'b0;
      x_valid     = 1'b0;

      // reset values
      #2;
      chk("rst_z", z, 1'b0);
      chk("rst_cnt", match_cnt, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", cfg_err, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      #10 rst = 1'b1;
      tick();

      // 0001, overlap, no target: two matches in 0001 0001
      configure(8'h01, 4'd4, 1'b1, 8'd0);
      chk("cfg1_err", cfg_err, 1'b0);
      start_run("t1");
      send4("t1a", 4'b0001, 4'b0001);
      chk("t1_cnt1", match_cnt, 8'd1);
      send4("t1b", 4'b0001, 4'b0001);
      chk("t1_cnt2", match_cnt, 8'd2);

      // start while busy is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_state", dbg_state, 2'd2);
      chk("busy_start_cnt", match_cnt, 8'd2);

      // abort holds the count
      do_abort();
      chk("abort_state", dbg_state, 2'd0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_cnt", match_cnt, 8'd2);

      // 11 overlapping in 1111 -> 3 matches
      configure(8'h03, 4'd2, 1'b1, 8'd0);
      start_run("t2");
      send4("t2", 4'b1111, 4'b0111);
      chk("t2_cnt", match_cnt, 8'd3);
      do_abort();

      // 11 non-overlapping in 1111 -> 2 matches
      configure(8'h03, 4'd2, 1'b0, 8'd0);
      start_run("t3");
      send4("t3", 4'b1111, 4'b0101);
      chk("t3_cnt", match_cnt, 8'd2);
      do_abort();

      // target 3: run ends on the third match, fourth occurrence ignored
      configure(8'h01, 4'd4, 1'b1, 8'd3);
      start_run("t4");
      send4("t4a", 4'b0001, 4'b0001);
      chk("t4_busy_mid", busy, 1'b1);
      send4("t4b", 4'b0001, 4'b0001);
      send4("t4c", 4'b0001, 4'b0001);
      chk("t4_cnt", match_cnt, 8'd3);
      chk("t4_done", done, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_state", dbg_state, 2'd3);
      send4("t4d", 4'b0001, 4'b0000);
      chk("t4_cnt_held", match_cnt, 8'd3);
      chk("t4_done_held", done, 1'b1);

      // start and abort together from DONE: abort wins
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_state", dbg_state, 2'd0);
      chk("sa_cnt", match_cnt, 8'd3);

      // gapped x_valid: single match, z only after the last valid bit
      configure(8'h01, 4'd4, 1'b1, 8'd0);
      start_run("t5");
      send_bit("t5_b0", 1'b0, 1'b0);
      tick(); chk("t5_gap0", z, 1'b0);
      send_bit("t5_b1", 1'b0, 1'b0);
      tick(); chk("t5_gap1", z, 1'b0);
      send_bit("t5_b2", 1'b0, 1'b0);
      tick(); chk("t5_gap2", z, 1'b0);
      send_bit("t5_b3", 1'b1, 1'b1);
      tick(); chk("t5_gap3", z, 1'b0);
      tick(); chk("t5_gap4", z, 1'b0);
      chk("t5_cnt", match_cnt, 8'd1);

      // cfg_we during RUN has no effect: 11 must not match, 0001 still does
      configure(8'hFF, 4'd2, 1'b1, 8'd1);
      chk("t6_state", dbg_state, 2'd2);
      send4("t6a", 4'b0001, 4'b0001);
      send_bit("t6_b4", 1'b1, 1'b0);
      send_bit("t6_b5", 1'b1, 1'b0);
      chk("t6_cnt", match_cnt, 8'd2);
      chk("t6_busy", busy, 1'b1);
      do_abort();

      // illegal lengths set cfg_err and keep the old config
      configure(8'hFF, 4'd0, 1'b0, 8'd5);
      chk("len0_err", cfg_err, 1'b1);
      configure(8'hFF, 4'd9, 1'b0, 8'd5);
      chk("len9_err", cfg_err, 1'b1);
      start_run("t7");
      send4("t7", 4'b0001, 4'b0001);
      chk("t7_cnt", match_cnt, 8'd1);
      chk("t7_err_sticky", cfg_err, 1'b1);

      // asynchronous reset between edges
      #3 rst = 1'b0;
      #1;
      chk("arst_z", z, 1'b0);
      chk("arst_cnt", match_cnt, 8'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_err", cfg_err, 1'b0);
      chk("arst_state", dbg_state, 2'd0);
      #1 rst = 1'b1;
      tick();

      // default config after reset: pattern 0, length 1, overlap
      start_run("t8");
      send_bit("t8_b0", 1'b0, 1'b1);
      send_bit("t8_b1", 1'b1, 1'b0);
      send_bit("t8_b2", 1'b0, 1'b1);
      chk("t8_cnt", match_cnt, 8'd2);
      do_abort();

      // a legal write clears cfg_err
      configure(8'h00, 4'd0, 1'b1, 8'd0);
      chk("t9_err_set", cfg_err, 1'b1);
      configure(8'h01, 4'd8, 1'b1, 8'd0);
      chk("t9_err_clr", cfg_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
